// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scan-code receiver.
// Imported by the line filter and the receiver top.
package ps2_pkg;

  typedef logic [7:0] scan_code_t;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_t;

  localparam scan_code_t PS2_PREFIX_EXT = 8'hE0;
  localparam scan_code_t PS2_PREFIX_BRK = 8'hF0;

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser with optional stable-level glitch filter.
// FILTER_LEN=0 gives a plain synchronised line.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clock,
  input  logic reset_n,
  input  logic line_in,
  output logic line_out,
  output logic fall_event
);

  logic sync1;
  logic sync2;

  // Metastability guard for the asynchronous pin; idles high.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= line_in;
      sync2 <= sync1;
    end
  end

  generate
    if (FILTER_LEN == 0) begin : g_bypass
      logic prev;

      // Previous level, for a raw falling-edge strobe.
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) prev <= 1'b1;
        else          prev <= sync2;
      end

      assign line_out   = sync2;
      assign fall_event = prev & ~sync2;
    end else begin : g_filter
      localparam int CW = $clog2(FILTER_LEN + 1);

      logic [CW-1:0] cnt;
      logic          level;
      logic          fall;

      // Flip the level only after FILTER_LEN cycles at the other value.
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          cnt   <= '0;
          level <= 1'b1;
          fall  <= 1'b0;
        end else begin
          fall <= 1'b0;
          if (sync2 == level) begin
            cnt <= '0;
          end else if (cnt == CW'(FILTER_LEN - 1)) begin
            cnt   <= '0;
            level <= sync2;
            fall  <= ~sync2;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      end

      assign line_out   = level;
      assign fall_event = fall;
    end
  endgenerate

endmodule

// File: rtl/ps2_scan_receiver.sv
// PS/2 frame receiver: framing, parity, timeout and E0/F0 prefixes.
// Emits one-cycle code_valid / frame_error events downstream.
module ps2_scan_receiver
  import ps2_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int TIMEOUT_US  = 200,
  parameter int FILTER_LEN  = 8
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       ps2_clock,
  input  logic       ps2_data,
  output logic [7:0] code,
  output logic       code_valid,
  output logic       code_break,
  output logic       code_extended,
  output logic       frame_error
);

  localparam int TIMEOUT_CYCLES = CLK_FREQ_HZ / 1_000_000 * TIMEOUT_US;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic fall;
  logic clk_level;
  logic data;
  logic data_fall;
  logic unused_ok;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clock      (clock),
    .reset_n    (reset_n),
    .line_in    (ps2_clock),
    .line_out   (clk_level),
    .fall_event (fall)
  );

  ps2_line_filter #(.FILTER_LEN(0)) u_data_sync (
    .clock      (clock),
    .reset_n    (reset_n),
    .line_in    (ps2_data),
    .line_out   (data),
    .fall_event (data_fall)
  );

  assign unused_ok = &{1'b0, clk_level, data_fall};

  ps2_state_t    state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  scan_code_t    shreg_q, shreg_d;
  logic          par_q, par_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          ext_q, ext_d;
  logic          brk_q, brk_d;
  scan_code_t    code_d;
  logic          valid_d, break_d, extended_d, error_d;

  // All receiver state advances here.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      bit_cnt_q     <= '0;
      shreg_q       <= '0;
      par_q         <= 1'b0;
      tcnt_q        <= '0;
      ext_q         <= 1'b0;
      brk_q         <= 1'b0;
      code          <= '0;
      code_valid    <= 1'b0;
      code_break    <= 1'b0;
      code_extended <= 1'b0;
      frame_error   <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      shreg_q       <= shreg_d;
      par_q         <= par_d;
      tcnt_q        <= tcnt_d;
      ext_q         <= ext_d;
      brk_q         <= brk_d;
      code          <= code_d;
      code_valid    <= valid_d;
      code_break    <= break_d;
      code_extended <= extended_d;
      frame_error   <= error_d;
    end
  end

  // Frame FSM; a clock fall wins over a timeout in the same cycle.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    par_d      = par_q;
    tcnt_d     = tcnt_q;
    ext_d      = ext_q;
    brk_d      = brk_q;
    code_d     = code;
    valid_d    = 1'b0;
    break_d    = code_break;
    extended_d = code_extended;
    error_d    = 1'b0;
    if (fall) begin
      tcnt_d = '0;
      unique case (state_q)
        IDLE: begin
          if (!data) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end
        end
        DATA: begin
          shreg_d   = {data, shreg_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_d   = data;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (data && (^{shreg_q, par_q})) begin
            if (shreg_q == PS2_PREFIX_EXT) begin
              ext_d = 1'b1;
            end else if (shreg_q == PS2_PREFIX_BRK) begin
              brk_d = 1'b1;
            end else begin
              code_d     = shreg_q;
              break_d    = brk_q;
              extended_d = ext_q;
              valid_d    = 1'b1;
              ext_d      = 1'b0;
              brk_d      = 1'b0;
            end
          end else begin
            error_d = 1'b1;
            ext_d   = 1'b0;
            brk_d   = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE) begin
      if (tcnt_q == TW'(TIMEOUT_CYCLES)) begin
        state_d = IDLE;
        tcnt_d  = '0;
        error_d = 1'b1;
        ext_d   = 1'b0;
        brk_d   = 1'b0;
      end else begin
        tcnt_d = tcnt_q + 1'b1;
      end
    end else begin
      tcnt_d = '0;
    end
  end

endmodule

// File: tb/tb_ps2_scan_receiver.sv
// Self-checking bench for ps2_scan_receiver.
// Frames are bit-banged on the raw pins and compared to a byte-level model.
module tb_ps2_scan_receiver;

  localparam int HALF = 24;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       ps2_clock = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] code;
  logic       code_valid;
  logic       code_break;
  logic       code_extended;
  logic       frame_error;

  ps2_scan_receiver dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .ps2_clock     (ps2_clock),
    .ps2_data      (ps2_data),
    .code          (code),
    .code_valid    (code_valid),
    .code_break    (code_break),
    .code_extended (code_extended),
    .frame_error   (frame_error)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [7:0] c;
    logic       b;
    logic       e;
  } ev_t;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  ev_t  obs_q[$];
  ev_t  exp_q[$];
  int   obs_err = 0;
  int   exp_err = 0;
  int   both_high = 0;
  int   last_valid_cyc = 0;
  int   last_err_cyc = 0;
  int   last_fall_cyc = 0;
  bit   m_ext = 0;
  bit   m_brk = 0;
  logic [7:0] m_code = 8'h00;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (reset_n) begin
      if (code_valid) begin
        obs_q.push_back('{code, code_break, code_extended});
        last_valid_cyc = cyc;
      end
      if (frame_error) begin
        obs_err++;
        last_err_cyc = cyc;
      end
      if (code_valid && frame_error) both_high++;
    end
  end

  // Byte-level reference: what one received frame means downstream.
  task automatic model_frame(input logic [7:0] b, input bit good);
    if (!good) begin
      exp_err++;
      m_ext = 0;
      m_brk = 0;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else begin
      exp_q.push_back('{b, m_brk, m_ext});
      m_code = b;
      m_ext = 0;
      m_brk = 0;
    end
  endtask

  task automatic clear_obs();
    obs_q.delete();
    exp_q.delete();
    obs_err = 0;
    exp_err = 0;
  endtask

  // Drive nbits of a frame; optional extra low pulse after bit gbit.
  task automatic send_frame(input logic [7:0] b, input bit bad_par,
                            input int nbits, input int gbit,
                            input int glen);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(negedge clock);
      ps2_data = f[i];
      repeat (HALF / 2) @(negedge clock);
      ps2_clock = 1'b0;
      last_fall_cyc = cyc;
      repeat (HALF) @(negedge clock);
      ps2_clock = 1'b1;
      if (i == gbit) begin
        repeat (15) @(negedge clock);
        ps2_clock = 1'b0;
        repeat (glen) @(negedge clock);
        ps2_clock = 1'b1;
      end
      repeat (HALF) @(negedge clock);
    end
    ps2_data = 1'b1;
    repeat (40) @(negedge clock);
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({code, code_valid, code_break, code_extended, frame_error} !== 12'h0) begin
      failures++;
      $display("FAIL reset_hold outs=%h want 0",
               {code, code_valid, code_break, code_extended, frame_error});
    end
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (5) @(negedge clock);
    send_frame(8'h1C, 0, 11, -1, 0);
    send_frame(8'hF0, 0, 11, -1, 0);
    send_frame(8'hE0, 0, 5, -1, 0);
    reset_n = 1'b0;
    #1;
    checks++;
    if ({code, code_valid, code_break, code_extended, frame_error} !== 12'h0) begin
      failures++;
      $display("FAIL reset_mid outs=%h want 0",
               {code, code_valid, code_break, code_extended, frame_error});
    end
    m_ext = 0;
    m_brk = 0;
    m_code = 8'h00;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    clear_obs();
    repeat (5) @(negedge clock);
    send_frame(8'h1D, 0, 11, -1, 0);
    model_frame(8'h1D, 1);
    checks++;
    if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
      failures++;
      $display("FAIL reset_first n=%0d got=%h want=%h",
               obs_q.size(), obs_q.size() ? obs_q[0] : ev_t'(0), exp_q[0]);
    end
    checks++;
    if (obs_err !== 0) begin
      failures++;
      $display("FAIL reset_noerr errs=%0d want 0", obs_err);
    end
    checks++;
    if (last_valid_cyc - last_fall_cyc < 10 ||
        last_valid_cyc - last_fall_cyc > 12) begin
      failures++;
      $display("FAIL latency got=%0d want 11+-1",
               last_valid_cyc - last_fall_cyc);
    end
    checks++;
    if (code !== 8'h1D || code_valid !== 1'b0) begin
      failures++;
      $display("FAIL code_hold code=%h v=%b want 1d 0", code, code_valid);
    end
    clear_obs();
  endtask

  task automatic test_break();
    send_frame(8'hF0, 0, 11, -1, 0);
    model_frame(8'hF0, 1);
    checks++;
    if (obs_q.size() != 0) begin
      failures++;
      $display("FAIL brk_prefix_pulse n=%0d want 0", obs_q.size());
    end
    send_frame(8'h1D, 0, 11, -1, 0);
    model_frame(8'h1D, 1);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL brk_count got=%0d want=%0d", obs_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL brk_ev%0d got=%h want=%h", i, obs_q[i], exp_q[i]);
        end
      end
    end
    clear_obs();
  endtask

  task automatic test_extended();
    logic [7:0] seq [6];
    seq = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 8'h1D};
    foreach (seq[i]) begin
      send_frame(seq[i], 0, 11, -1, 0);
      model_frame(seq[i], 1);
    end
    checks++;
    if (obs_q.size() != exp_q.size() || exp_q.size() != 3) begin
      failures++;
      $display("FAIL ext_count got=%0d want=%0d", obs_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL ext_ev%0d got=%h want=%h", i, obs_q[i], exp_q[i]);
        end
      end
    end
    checks++;
    if (obs_err !== 0) begin
      failures++;
      $display("FAIL ext_noerr errs=%0d want 0", obs_err);
    end
    clear_obs();
  endtask

  task automatic test_parity();
    send_frame(8'h1D, 1, 11, -1, 0);
    model_frame(8'h1D, 0);
    checks++;
    if (obs_err !== exp_err || obs_q.size() != 0) begin
      failures++;
      $display("FAIL par_err errs=%0d valids=%0d want %0d 0",
               obs_err, obs_q.size(), exp_err);
    end
    checks++;
    if (code !== m_code) begin
      failures++;
      $display("FAIL par_hold code=%h want=%h", code, m_code);
    end
    send_frame(8'h1C, 0, 11, -1, 0);
    model_frame(8'h1C, 1);
    checks++;
    if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
      failures++;
      $display("FAIL par_recover n=%0d want %h", obs_q.size(), exp_q[0]);
    end
    clear_obs();
  endtask

  task automatic test_timeout();
    int gap;
    send_frame(8'hF0, 0, 11, -1, 0);
    model_frame(8'hF0, 1);
    send_frame(8'h55, 0, 5, -1, 0);
    repeat (25000) @(negedge clock);
    exp_err++;
    m_ext = 0;
    m_brk = 0;
    gap = last_err_cyc - last_fall_cyc;
    checks++;
    if (obs_err !== exp_err) begin
      failures++;
      $display("FAIL tmo_err errs=%0d want=%0d", obs_err, exp_err);
    end
    checks++;
    if (gap < 20009 || gap > 20013) begin
      failures++;
      $display("FAIL tmo_gap got=%0d want 20011+-2", gap);
    end
    send_frame(8'h1D, 0, 11, -1, 0);
    model_frame(8'h1D, 1);
    checks++;
    if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
      failures++;
      $display("FAIL tmo_clear n=%0d want %h", obs_q.size(), exp_q[0]);
    end
    clear_obs();
  endtask

  task automatic test_glitch();
    for (int g = 1; g < 9; g += 3) begin
      send_frame(8'h1D, 0, 11, g, 3);
      model_frame(8'h1D, 1);
    end
    checks++;
    if (obs_err !== 0 || obs_q.size() != 3) begin
      failures++;
      $display("FAIL glitch_short errs=%0d valids=%0d want 0 3",
               obs_err, obs_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL glitch_ev%0d got=%h want=%h", i, obs_q[i], exp_q[i]);
        end
      end
    end
    clear_obs();
    send_frame(8'h1D, 0, 11, 0, 10);
    model_frame(8'h3A, ^{8'h3A, 1'b0});
    checks++;
    if (obs_err !== exp_err || obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL glitch_long errs=%0d valids=%0d want %0d %0d",
               obs_err, obs_q.size(), exp_err, exp_q.size());
    end
    clear_obs();
  endtask

  task automatic test_random();
    logic [7:0] b;
    bit bad;
    for (int n = 0; n < 25; n++) begin
      case ($urandom_range(0, 9))
        0: b = 8'hE0;
        1: b = 8'hF0;
        default: b = 8'($urandom);
      endcase
      bad = ($urandom_range(0, 6) == 0);
      send_frame(b, bad, 11, -1, 0);
      model_frame(b, !bad);
    end
    checks++;
    if (obs_err !== exp_err) begin
      failures++;
      $display("FAIL rnd_errs got=%0d want=%0d", obs_err, exp_err);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL rnd_count got=%0d want=%0d", obs_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL rnd_ev%0d got=%h want=%h", i, obs_q[i], exp_q[i]);
        end
      end
    end
    checks++;
    if (both_high !== 0) begin
      failures++;
      $display("FAIL both_high got=%0d want 0", both_high);
    end
    clear_obs();
  endtask

  initial begin
    test_reset();
    test_break();
    test_extended();
    test_parity();
    test_timeout();
    test_glitch();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
